ikaopm_bus_writer: RTL and testbench

Host-side register write sequencer that sits directly upstream of the IKAOPM core's CPU bus. It accepts (register address, data) write requests over a valid/ready handshake and buffers them in a small FIFO. Each request is replayed as a YM2151-style bus transaction: an address cycle with A0=0, a data cycle with A0=1, then a busy-wait counted in phiM enables. It replaces hand-timed bus wiggling for both system integration and benches.

---
 rtl/ikaopm_bus_writer_if.sv | 40 ++++
 rtl/ikaopm_bus_writer.sv | 226 ++++++++++++++++++++++
 tb/tb_ikaopm_bus_writer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ikaopm_bus_writer_if.sv
// Request handshake plus YM2151-style CPU bus bundle
// between a host and the IKAOPM bus writer.
interface ikaopm_bus_writer_if;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic [7:0] REQ_ADDR;
  logic [7:0] REQ_DATA;
  logic       CS_n;
  logic       WR_n;
  logic       RD_n;
  logic       A0;
  logic [7:0] D;
  logic       BUSY;

  modport slave (
    input  REQ_VALID,
    input  REQ_ADDR,
    input  REQ_DATA,
    output REQ_READY,
    output CS_n,
    output WR_n,
    output RD_n,
    output A0,
    output D,
    output BUSY
  );

  modport master (
    output REQ_VALID,
    output REQ_ADDR,
    output REQ_DATA,
    input  REQ_READY,
    input  CS_n,
    input  WR_n,
    input  RD_n,
    input  A0,
    input  D,
    input  BUSY
  );
endinterface

// File: rtl/ikaopm_bus_writer.sv
// Queued register-write sequencer that replays each request as an
// address cycle, a data cycle and a phiM-counted busy wait.
module ikaopm_bus_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 3,
  parameter int PULSE_CYC  = 4,
  parameter int HOLD_CYC   = 3,
  parameter int BUSY_WAIT  = 68
) (
  input  logic               i_EMUCLK,
  input  logic               i_RST,
  input  logic               i_phiM_PCEN_n,
  ikaopm_bus_writer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 16;

  typedef enum logic [2:0] {
    IDLE,
    A_SETUP,
    A_PULSE,
    A_HOLD,
    D_SETUP,
    D_PULSE,
    D_HOLD,
    WAIT
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  logic [7:0]    fifo_addr [FIFO_DEPTH];
  logic [7:0]    fifo_data [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          full;
  logic          empty;
  logic          push;
  logic          launch;

  logic [7:0]    wdata;
  logic [7:0]    wdata_nxt;
  logic          cs_n_q;
  logic          wr_n_q;
  logic          a0_q;
  logic [7:0]    d_q;
  logic          busy_q;
  logic          cs_n_nxt;
  logic          wr_n_nxt;
  logic          a0_nxt;
  logic [7:0]    d_nxt;
  logic          busy_nxt;

  // Ready reflects fullness before any pop on the same edge.
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push      = bus.REQ_VALID & ~full;
  assign count_nxt = count + (AW+1)'(push)
                   - (AW+1)'(launch);

  assign bus.REQ_READY = ~full;
  assign bus.CS_n      = cs_n_q;
  assign bus.WR_n      = wr_n_q;
  assign bus.RD_n      = 1'b1;
  assign bus.A0        = a0_q;
  assign bus.D         = d_q;
  assign bus.BUSY      = busy_q;

  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (launch) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.REQ_ADDR;
      fifo_data[wr_ptr] <= bus.REQ_DATA;
    end
  end

  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end

  // One shared down-counter, reloaded with (length-1) on every entry.
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    launch  = 1'b0;
    unique case (state)
      IDLE: begin
        launch = ~empty;
      end
      A_SETUP: begin
        if (cnt == '0) begin
          nxt     = A_PULSE;
          cnt_nxt = CW'(PULSE_CYC - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      A_PULSE: begin
        if (cnt == '0) begin
          nxt     = A_HOLD;
          cnt_nxt = CW'(HOLD_CYC - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      A_HOLD: begin
        if (cnt == '0) begin
          nxt     = D_SETUP;
          cnt_nxt = CW'(SETUP_CYC - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      D_SETUP: begin
        if (cnt == '0) begin
          nxt     = D_PULSE;
          cnt_nxt = CW'(PULSE_CYC - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      D_PULSE: begin
        if (cnt == '0) begin
          nxt     = D_HOLD;
          cnt_nxt = CW'(HOLD_CYC - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      D_HOLD: begin
        if (cnt == '0) begin
          if (BUSY_WAIT == 0) begin
            nxt    = IDLE;
            launch = ~empty;
          end else begin
            nxt     = WAIT;
            cnt_nxt = CW'(BUSY_WAIT);
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      WAIT: begin
        // Frozen while phiM enables are absent.
        if (!i_phiM_PCEN_n) begin
          if (cnt <= CW'(1)) begin
            nxt    = IDLE;
            launch = ~empty;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
      end
      default: begin
        nxt = IDLE;
      end
    endcase
    if (launch) begin
      nxt     = A_SETUP;
      cnt_nxt = CW'(SETUP_CYC - 1);
    end
  end

  // Pins are registered from the next state.
  always_comb begin
    cs_n_nxt  = ~(nxt inside {A_SETUP, A_PULSE,
                              D_SETUP, D_PULSE});
    wr_n_nxt  = ~(nxt inside {A_PULSE, D_PULSE});
    a0_nxt    = a0_q;
    d_nxt     = d_q;
    wdata_nxt = wdata;
    if (launch) begin
      a0_nxt    = 1'b0;
      d_nxt     = fifo_addr[rd_ptr];
      wdata_nxt = fifo_data[rd_ptr];
    end else if (state == A_HOLD &&
                 nxt == D_SETUP) begin
      a0_nxt = 1'b1;
      d_nxt  = wdata;
    end
    busy_nxt = (count_nxt != '0) || (nxt != IDLE);
  end

  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      cs_n_q <= 1'b1;
      wr_n_q <= 1'b1;
      a0_q   <= 1'b0;
      d_q    <= '0;
      busy_q <= 1'b0;
      wdata  <= '0;
    end else begin
      cs_n_q <= cs_n_nxt;
      wr_n_q <= wr_n_nxt;
      a0_q   <= a0_nxt;
      d_q    <= d_nxt;
      busy_q <= busy_nxt;
      wdata  <= wdata_nxt;
    end
  end
endmodule

// File: tb/tb_ikaopm_bus_writer.sv
// Directed bench for ikaopm_bus_writer: timing, queueing,
// backpressure, phiM stall and reset abort.
module tb_ikaopm_bus_writer;
  logic clk = 1'b0;
  logic rst;
  logic pcen_n;

  always #5 clk = ~clk;

  ikaopm_bus_writer_if bif ();
  ikaopm_bus_writer_if bif0 ();

  ikaopm_bus_writer #(.BUSY_WAIT(68)) dut (
    .i_EMUCLK      (clk),
    .i_RST         (rst),
    .i_phiM_PCEN_n (pcen_n),
    .bus           (bif)
  );

  ikaopm_bus_writer #(.BUSY_WAIT(0)) dut0 (
    .i_EMUCLK      (clk),
    .i_RST         (rst),
    .i_phiM_PCEN_n (pcen_n),
    .bus           (bif0)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (bif.BUSY !== 1'b0 && k < budget) begin
      tick();
      k++;
    end
    chk(tag, bif.BUSY, 1'b0);
  endtask

  // Bus monitor on the main instance.
  logic [8:0] wlog [$];
  int         plen [$];
  int         gaps [$];
  logic [7:0] regs [256];
  logic [7:0] lat_addr = 8'h00;
  logic       pcs = 1'b1;
  logic       pwr = 1'b1;
  int         cyc = 0;
  int         wlen = 0;
  int         last_rise = -1;

  always @(negedge clk) begin
    cyc++;
    if (!bif.BUSY) last_rise = -1;
    if (!bif.WR_n) wlen++;
    if (pwr && !bif.WR_n) chk("wr_fall_cs_low", pcs, 1'b0);
    if (!pwr && bif.WR_n) begin
      chk("wr_rise_cs_high", bif.CS_n, 1'b1);
      wlog.push_back({bif.A0, bif.D});
      plen.push_back(wlen);
      if (bif.A0) begin
        regs[lat_addr] = bif.D;
        last_rise = cyc;
      end else begin
        lat_addr = bif.D;
      end
    end
    if (pwr && bif.WR_n) wlen = 0;
    if (pcs && !bif.CS_n && !bif.A0 && last_rise >= 0) begin
      gaps.push_back(cyc - last_rise);
      last_rise = -1;
    end
    pcs = bif.CS_n;
    pwr = bif.WR_n;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [8:0]  exp2 [6];
  logic        rdy [0:127];
  logic        bsy [0:150];
  int          acc_edge [6];
  logic [11:0] ev;
  logic        was_rdy;
  int          acc;
  int          n0;
  logic        cs60;

  initial begin
    rst = 1'b1;
    pcen_n = 1'b0;
    bif.REQ_VALID = 1'b0;
    bif.REQ_ADDR = 8'h00;
    bif.REQ_DATA = 8'h00;
    bif0.REQ_VALID = 1'b0;
    bif0.REQ_ADDR = 8'h00;
    bif0.REQ_DATA = 8'h00;
    for (int i = 0; i < 256; i++) regs[i] = 8'hAA;
    repeat (3) tick();

    chk("rst_cs", bif.CS_n, 1'b1);
    chk("rst_wr", bif.WR_n, 1'b1);
    chk("rst_rd", bif.RD_n, 1'b1);
    chk("rst_a0", bif.A0, 1'b0);
    chk("rst_d", bif.D, 8'h00);
    chk("rst_busy", bif.BUSY, 1'b0);
    chk("rst_ready", bif.REQ_READY, 1'b1);
    rst = 1'b0;
    tick();

    // Single write, no busy wait.
    bif0.REQ_VALID = 1'b1;
    bif0.REQ_ADDR = 8'h18;
    bif0.REQ_DATA = 8'hFF;
    tick();
    bif0.REQ_VALID = 1'b0;
    chk("t1_k0", {bif0.CS_n, bif0.BUSY}, 2'b11);
    for (int k = 1; k <= 22; k++) begin
      tick();
      ev[11] = !((k >= 1 && k <= 7) || (k >= 11 && k <= 17));
      ev[10] = !((k >= 4 && k <= 7) || (k >= 14 && k <= 17));
      ev[9]  = (k >= 11);
      ev[8:1] = (k >= 11) ? 8'hFF : 8'h18;
      ev[0]  = (k <= 20);
      chk($sformatf("t1_k%0d", k),
          {bif0.CS_n, bif0.WR_n, bif0.A0, bif0.D, bif0.BUSY}, ev);
    end

    // Three back-to-back requests with busy wait.
    bif.REQ_VALID = 1'b1;
    bif.REQ_ADDR = 8'h1B; bif.REQ_DATA = 8'h01;
    tick();
    bif.REQ_ADDR = 8'h28; bif.REQ_DATA = 8'h4E;
    tick();
    bif.REQ_ADDR = 8'h38; bif.REQ_DATA = 8'h00;
    tick();
    bif.REQ_VALID = 1'b0;
    wait_idle("t2_idle", 600);
    exp2 = '{9'h01B, 9'h101, 9'h028, 9'h14E, 9'h038, 9'h100};
    chk("t2_nstrobes", wlog.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t2_strobe%0d", i), wlog[i], exp2[i]);
      chk($sformatf("t2_plen%0d", i), plen[i], 4);
    end
    chk("t2_ngaps", gaps.size(), 2);
    chk("t2_gap0", gaps[0], 71);
    chk("t2_gap1", gaps[1], 71);
    chk("t2_reg1b", regs[8'h1B], 8'h01);
    chk("t2_reg28", regs[8'h28], 8'h4E);
    chk("t2_reg38", regs[8'h38], 8'h00);

    // Backpressure with six requests held valid.
    wlog.delete();
    plen.delete();
    gaps.delete();
    acc = 0;
    for (int k = 1; k <= 100; k++) begin
      if (acc < 6) begin
        bif.REQ_VALID = 1'b1;
        bif.REQ_ADDR = 8'h40 + 8'(acc);
        bif.REQ_DATA = 8'hC0 + 8'(acc);
      end else begin
        bif.REQ_VALID = 1'b0;
      end
      was_rdy = bif.REQ_READY;
      tick();
      if (acc < 6 && was_rdy) begin
        acc_edge[acc] = k;
        acc++;
      end
      rdy[k] = bif.REQ_READY;
    end
    bif.REQ_VALID = 1'b0;
    chk("t3_rdy4", rdy[4], 1'b1);
    chk("t3_rdy5", rdy[5], 1'b0);
    chk("t3_rdy89", rdy[89], 1'b0);
    chk("t3_rdy90", rdy[90], 1'b1);
    chk("t3_rdy91", rdy[91], 1'b0);
    chk("t3_acc", acc, 6);
    chk("t3_acc4_edge", acc_edge[4], 5);
    chk("t3_acc5_edge", acc_edge[5], 91);
    wait_idle("t3_idle", 700);
    chk("t3_nstrobes", wlog.size(), 12);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3_a%0d", i), wlog[2*i], {1'b0, 8'h40 + 8'(i)});
      chk($sformatf("t3_d%0d", i), wlog[2*i+1], {1'b1, 8'hC0 + 8'(i)});
    end

    // phiM enables withheld during WAIT.
    bif.REQ_VALID = 1'b1;
    bif.REQ_ADDR = 8'h20;
    bif.REQ_DATA = 8'h55;
    tick();
    bif.REQ_VALID = 1'b0;
    cs60 = 1'b0;
    for (int k = 1; k <= 140; k++) begin
      tick();
      if (k == 30) pcen_n = 1'b1;
      if (k == 80) pcen_n = 1'b0;
      if (k == 60) cs60 = bif.CS_n;
      bsy[k] = bif.BUSY;
    end
    chk("t5_cs60", cs60, 1'b1);
    chk("t5_bsy60", bsy[60], 1'b1);
    chk("t5_bsy89", bsy[89], 1'b1);
    chk("t5_bsy138", bsy[138], 1'b1);
    chk("t5_bsy139", bsy[139], 1'b0);

    // Reset during D_PULSE with two entries queued.
    bif.REQ_VALID = 1'b1;
    bif.REQ_ADDR = 8'h60; bif.REQ_DATA = 8'h11;
    tick();
    bif.REQ_ADDR = 8'h61; bif.REQ_DATA = 8'h12;
    tick();
    bif.REQ_ADDR = 8'h62; bif.REQ_DATA = 8'h13;
    tick();
    bif.REQ_VALID = 1'b0;
    repeat (13) tick();
    chk("t6_in_dpulse", {bif.CS_n, bif.WR_n, bif.A0}, 3'b001);
    rst = 1'b1;
    #1;
    chk("t6_rst_wr", bif.WR_n, 1'b1);
    chk("t6_rst_cs", bif.CS_n, 1'b1);
    chk("t6_rst_a0", bif.A0, 1'b0);
    chk("t6_rst_d", bif.D, 8'h00);
    chk("t6_rst_busy", bif.BUSY, 1'b0);
    chk("t6_rst_ready", bif.REQ_READY, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    n0 = wlog.size();
    repeat (200) tick();
    chk("t6_no_stale", wlog.size(), n0);
    chk("t6_idle_cs", bif.CS_n, 1'b1);
    chk("t6_idle_busy", bif.BUSY, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
